nr_divider_pipe: RTL and testbench

//  Parametrised, fully pipelined non-restoring integer divider; successor to Divider_Modulo.
//  - One operation accepted per clock.
//  - Per-op mode selects quotient or remainder.
//  - Adds downstream backpressure and a divide-by-zero flag.
//  - Adds an optional signed mode (SIGNED_DIV_EN).
//  - Sits between the operand source and the result consumer in the arithmetic datapath.

---
 rtl/nr_div_pkg.sv | 22 ++
 rtl/nr_div_stage.sv | 70 +++++++
 rtl/nr_divider_pipe.sv | 139 +++++++++++++
 tb/tb_nr_divider_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nr_div_pkg.sv
// Shared control payload, mode encodings and latency helper for the
// pipelined non-restoring divider.
package nr_div_pkg;

    localparam logic MODE_QUO = 1'b0;
    localparam logic MODE_REM = 1'b1;

    // Per-op control bits that travel alongside the datapath in every stage.
    typedef struct packed {
        logic valid;
        logic mode;
        logic sgn_q;
        logic sgn_r;
        logic div0;
    } nr_ctrl_t;

    // Accept-to-valid_out latency: one register per iteration stage plus the output stage.
    function automatic int nr_latency(input int dividend_w, input int bits_per_stage);
        return dividend_w / bits_per_stage + 1;
    endfunction

endpackage

// File: rtl/nr_div_stage.sv
// One registered non-restoring iteration stage: resolves BITS_PER_STAGE quotient
// bits and holds all of its state while en is low.
module nr_div_stage
    import nr_div_pkg::*;
#(
    parameter int DIVIDEND_W     = 32,
    parameter int DIVISOR_W      = 16,
    parameter int BITS_PER_STAGE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  nr_ctrl_t              ctrl_in,
    input  logic [DIVISOR_W:0]    p_in,
    input  logic [DIVIDEND_W-1:0] q_in,
    input  logic [DIVIDEND_W-1:0] n_in,
    input  logic [DIVISOR_W-1:0]  d_in,
    output nr_ctrl_t              ctrl_out,
    output logic [DIVISOR_W:0]    p_out,
    output logic [DIVIDEND_W-1:0] q_out,
    output logic [DIVIDEND_W-1:0] n_out,
    output logic [DIVISOR_W-1:0]  d_out
);

    nr_ctrl_t              ctrl_reg;
    logic [DIVISOR_W:0]    p_reg, p_next;
    logic [DIVIDEND_W-1:0] q_reg, q_next;
    logic [DIVIDEND_W-1:0] n_reg, n_next;
    logic [DIVISOR_W-1:0]  d_reg;

    // P lives in DIVISOR_W+1 bits; 2P+bit wraps, but the +/-D step always lands
    // back inside [-D, D), so modular arithmetic gives the exact value.
    always_comb begin
        p_next = p_in;
        q_next = q_in;
        n_next = n_in;
        for (int b = 0; b < BITS_PER_STAGE; b++) begin
            if (p_next[DIVISOR_W]) begin
                p_next = {p_next[DIVISOR_W-1:0], n_next[DIVIDEND_W-1]} + {1'b0, d_in};
            end else begin
                p_next = {p_next[DIVISOR_W-1:0], n_next[DIVIDEND_W-1]} - {1'b0, d_in};
            end
            q_next = {q_next[DIVIDEND_W-2:0], ~p_next[DIVISOR_W]};
            n_next = {n_next[DIVIDEND_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_reg <= '0;
            p_reg    <= '0;
            q_reg    <= '0;
            n_reg    <= '0;
            d_reg    <= '0;
        end else if (en) begin
            ctrl_reg <= ctrl_in;
            p_reg    <= p_next;
            q_reg    <= q_next;
            n_reg    <= n_next;
            d_reg    <= d_in;
        end
    end

    assign ctrl_out = ctrl_reg;
    assign p_out    = p_reg;
    assign q_out    = q_reg;
    assign n_out    = n_reg;
    assign d_out    = d_reg;

endmodule

// File: rtl/nr_divider_pipe.sv
// Fully pipelined non-restoring divider with backpressure and divide-by-zero flag.
// Define SIGNED_DIV_EN to add two's-complement operation selected per op by signed_in.
module nr_divider_pipe
    import nr_div_pkg::*;
#(
    parameter int DIVIDEND_W     = 32,
    parameter int DIVISOR_W      = 16,
    parameter int BITS_PER_STAGE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  mode,
    input  logic                  signed_in,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] result,
    output logic                  div0_out,
    output logic                  valid_out,
    input  logic                  ready_in
);

    localparam int N_STAGES = nr_latency(DIVIDEND_W, BITS_PER_STAGE) - 1;

    nr_ctrl_t              ctrl_s [0:N_STAGES];
    logic [DIVISOR_W:0]    p_s    [0:N_STAGES];
    logic [DIVIDEND_W-1:0] q_s    [0:N_STAGES];
    logic [DIVIDEND_W-1:0] n_s    [0:N_STAGES];
    logic [DIVISOR_W-1:0]  d_s    [0:N_STAGES];

    nr_ctrl_t              ctrl_e;
    logic [DIVIDEND_W-1:0] n_e;
    logic [DIVISOR_W-1:0]  d_e;

    logic                  stall;
    logic                  valid_reg;
    logic                  div0_reg;
    logic [DIVIDEND_W-1:0] result_reg;
    logic [DIVIDEND_W-1:0] result_next;
    logic [DIVIDEND_W-1:0] quo_next;
    logic [DIVIDEND_W-1:0] rem_next;
    logic [DIVISOR_W-1:0]  rem_mag;

    // A full output register that cannot drain freezes the whole pipe.
    assign stall     = valid_reg && !ready_in;
    assign ready_out = !stall;

    // Entry: operand conditioning feeding the first iteration register.
    always_comb begin
        ctrl_e       = '0;
        ctrl_e.valid = valid_in;
        ctrl_e.mode  = mode;
        ctrl_e.div0  = (divisor == '0);
        n_e          = dividend;
        d_e          = divisor;
`ifdef SIGNED_DIV_EN
        // A zero divisor keeps the raw dividend so its low bits come back unchanged.
        if (signed_in && (divisor != '0)) begin
            ctrl_e.sgn_q = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            ctrl_e.sgn_r = dividend[DIVIDEND_W-1];
            n_e          = dividend[DIVIDEND_W-1] ? -dividend : dividend;
            d_e          = divisor[DIVISOR_W-1] ? -divisor : divisor;
            ctrl_e.div0  = (dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (divisor == '1);
        end
`endif
    end

    assign ctrl_s[0] = ctrl_e;
    assign p_s[0]    = '0;
    assign q_s[0]    = '0;
    assign n_s[0]    = n_e;
    assign d_s[0]    = d_e;

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
            nr_div_stage #(
                .DIVIDEND_W     (DIVIDEND_W),
                .DIVISOR_W      (DIVISOR_W),
                .BITS_PER_STAGE (BITS_PER_STAGE)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .en       (!stall),
                .ctrl_in  (ctrl_s[gi]),
                .p_in     (p_s[gi]),
                .q_in     (q_s[gi]),
                .n_in     (n_s[gi]),
                .d_in     (d_s[gi]),
                .ctrl_out (ctrl_s[gi+1]),
                .p_out    (p_s[gi+1]),
                .q_out    (q_s[gi+1]),
                .n_out    (n_s[gi+1]),
                .d_out    (d_s[gi+1])
            );
        end
    endgenerate

    // Correction/output: restore a negative remainder, apply divide-by-zero and sign rules.
    always_comb begin
        rem_mag  = p_s[N_STAGES][DIVISOR_W] ? p_s[N_STAGES][DIVISOR_W-1:0] + d_s[N_STAGES]
                                            : p_s[N_STAGES][DIVISOR_W-1:0];
        rem_next = DIVIDEND_W'(rem_mag);
        quo_next = (d_s[N_STAGES] == '0) ? '1 : q_s[N_STAGES];
`ifdef SIGNED_DIV_EN
        if (ctrl_s[N_STAGES].sgn_q) quo_next = -quo_next;
        if (ctrl_s[N_STAGES].sgn_r) rem_next = -rem_next;
`endif
        result_next = '0;
        if (ctrl_s[N_STAGES].valid) begin
            result_next = (ctrl_s[N_STAGES].mode == MODE_REM) ? rem_next : quo_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg  <= 1'b0;
            div0_reg   <= 1'b0;
            result_reg <= '0;
        end else if (!stall) begin
            valid_reg  <= ctrl_s[N_STAGES].valid;
            div0_reg   <= ctrl_s[N_STAGES].valid && ctrl_s[N_STAGES].div0;
            result_reg <= result_next;
        end
    end

    assign valid_out = valid_reg;
    assign div0_out  = div0_reg;
    assign result    = result_reg;

    logic unused_tail;
    assign unused_tail = ^n_s[N_STAGES];

`ifndef SIGNED_DIV_EN
    logic unused_sign;
    assign unused_sign = ^{signed_in, ctrl_s[N_STAGES].sgn_q, ctrl_s[N_STAGES].sgn_r};
`endif

endmodule

// File: tb/tb_nr_divider_pipe.sv
// Self-checking bench for nr_divider_pipe: directed cases with literal results plus
// randomized traffic against an arithmetic reference model (/ and %).
`timescale 1ns/1ps
module tb_nr_divider_pipe;
    import nr_div_pkg::*;

    localparam int DW  = 32;
    localparam int VW  = 16;
    localparam int BPS = 1;
    localparam int LAT = DW / BPS + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          valid_in = 1'b0;
    logic          mode = 1'b0;
    logic          signed_in = 1'b0;
    logic          ready_in = 1'b1;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          ready_out;
    logic          div0_out;
    logic          valid_out;
    logic [DW-1:0] result;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vout_seen = 0;

    typedef struct {
        logic [DW-1:0] res;
        logic          div0;
    } exp_t;

    exp_t expq[$];

    nr_divider_pipe #(
        .DIVIDEND_W     (DW),
        .DIVISOR_W      (VW),
        .BITS_PER_STAGE (BPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .mode      (mode),
        .signed_in (signed_in),
        .dividend  (dividend),
        .divisor   (divisor),
        .result    (result),
        .div0_out  (div0_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division semantics.
    function automatic exp_t model(input logic [DW-1:0] n, input logic [VW-1:0] d,
                                   input logic m, input logic s);
        exp_t e;
        e.div0 = (d == '0);
        if (d == '0) e.res = (m == MODE_REM) ? DW'(n[VW-1:0]) : '1;
        else         e.res = (m == MODE_REM) ? (n % DW'(d)) : (n / DW'(d));
`ifdef SIGNED_DIV_EN
        if (s && (d != '0)) begin
            longint sn = longint'($signed(n));
            longint sd = longint'($signed(d));
            e.res  = (m == MODE_REM) ? DW'(sn % sd) : DW'(sn / sd);
            e.div0 = (n == {1'b1, {(DW-1){1'b0}}}) && (d == '1);
        end
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
        end else begin
            chk("ready_out_rule", ready_out, !(valid_out && !ready_in));
            if (valid_out) begin
                vout_seen++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid: valid_out=1 result=%0h with no op outstanding", result);
                end else begin
                    chk("model_result", result, expq[0].res);
                    chk("model_div0", div0_out, expq[0].div0);
                    if (ready_in) void'(expq.pop_front());
                end
            end
            if (valid_in && ready_out) expq.push_back(model(dividend, divisor, mode, signed_in));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [DW-1:0] n, input logic [VW-1:0] d,
                         input logic m, input logic s);
        valid_in  = 1'b1;
        dividend  = n;
        divisor   = d;
        mode      = m;
        signed_in = s;
        tick();
        valid_in  = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [DW-1:0] r,
                              input logic d0, input int at_cyc);
        int n = 0;
        @(negedge clk);
        while (!valid_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, valid_out, 1'b1);
        chk({name, "_result"}, result, r);
        chk({name, "_div0"}, div0_out, d0);
        chk({name, "_cycle"}, cyc, at_cyc);
    endtask

    function automatic logic [DW-1:0] rnd_n();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return DW'($urandom_range(0, 1000));
            3:       return {1'b1, {(DW-1){1'b0}}};
            default: return DW'($urandom());
        endcase
    endfunction

    function automatic logic [VW-1:0] rnd_d();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return VW'(1);
            2:       return '1;
            3:       return VW'($urandom_range(1, 20));
            4:       return {1'b1, {(VW-1){1'b0}}};
            default: return VW'($urandom());
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int vs;
        int n;
        exp_t e;

        e = model(32'd537133248, 16'd25347, MODE_QUO, 1'b0);
        chk("model_pin_quo", e.res, 32'd21191);
        e = model(32'd537133248, 16'd25347, MODE_REM, 1'b0);
        chk("model_pin_rem", e.res, 32'd4971);

        #1 reset = 1'b1;
        #1;
        chk("reset_result", result, 0);
        chk("reset_valid", valid_out, 0);
        chk("reset_div0", div0_out, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_ready", ready_out, 1);

        c0 = cyc;
        drive(32'd537133248, 16'd25347, MODE_QUO, 1'b0);
        expect_out("quo", 32'd21191, 1'b0, c0 + LAT);
        tick();

        c0 = cyc;
        drive(32'd537133248, 16'd25347, MODE_REM, 1'b0);
        drive(32'd690275523, 16'd25443, MODE_QUO, 1'b0);
        expect_out("b2b_first", 32'd4971, 1'b0, c0 + LAT);
        expect_out("b2b_second", 32'd27130, 1'b0, c0 + LAT + 1);
        tick();

        c0 = cyc;
        drive(32'd537133248, 16'd3, MODE_QUO, 1'b0);
        drive(32'd537133248, 16'd3, MODE_REM, 1'b0);
        while (cyc != c0 + LAT) tick();
        ready_in = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_result", result, 32'd179044416);
            chk("bp_hold_valid", valid_out, 1);
            chk("bp_ready_low", ready_out, 0);
            tick();
        end
        ready_in = 1'b1;
        @(negedge clk);
        expect_out("bp_next", 32'd0, 1'b0, c0 + LAT + 6);
        tick();

        c0 = cyc;
        drive(32'd1234, 16'd0, MODE_REM, 1'b0);
        drive(32'd1234, 16'd0, MODE_QUO, 1'b0);
        expect_out("div0_rem", 32'd1234, 1'b1, c0 + LAT);
        expect_out("div0_quo", 32'hFFFF_FFFF, 1'b1, c0 + LAT + 1);
        tick();

        c0 = cyc;
        drive(32'hFFFF_FFF9, 16'd2, MODE_QUO, 1'b1);
        drive(32'hFFFF_FFF9, 16'd2, MODE_REM, 1'b1);
`ifdef SIGNED_DIV_EN
        expect_out("signed_quo", 32'hFFFF_FFFD, 1'b0, c0 + LAT);
        expect_out("signed_rem", 32'hFFFF_FFFF, 1'b0, c0 + LAT + 1);
`else
        expect_out("unsigned_quo", 32'h7FFF_FFFC, 1'b0, c0 + LAT);
        expect_out("unsigned_rem", 32'h0000_0001, 1'b0, c0 + LAT + 1);
`endif
        tick();

        // Reset with three ops in flight.
        drive(32'd100, 16'd7, MODE_QUO, 1'b0);
        drive(32'd200, 16'd9, MODE_REM, 1'b0);
        drive(32'd300, 16'd0, MODE_QUO, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        chk("rst_flight_result", result, 0);
        chk("rst_flight_valid", valid_out, 0);
        chk("rst_flight_div0", div0_out, 0);
        repeat (2) tick();
        reset = 1'b0;
        vs = vout_seen;
        repeat (LAT + 10) tick();
        chk("rst_flight_no_output", vout_seen - vs, 0);

        // Reset while a result is held at the output.
        drive(32'd1000, 16'd7, MODE_QUO, 1'b0);
        n = 0;
        while (!valid_out && n < 100) begin
            tick();
            n++;
        end
        ready_in = 1'b0;
        @(negedge clk);
        chk("rst_held_result", result, 32'd142);
        #1 reset = 1'b1;
        #1;
        chk("rst_held_result_cleared", result, 0);
        chk("rst_held_valid_cleared", valid_out, 0);
        chk("rst_held_ready", ready_out, 1);
        repeat (2) tick();
        reset = 1'b0;
        ready_in = 1'b1;
        tick();

        for (int i = 0; i < 400; i++) begin
            ready_in = ($urandom_range(0, 3) != 0);
            #1;
            valid_in  = ready_out && ($urandom_range(0, 4) != 0);
            dividend  = rnd_n();
            divisor   = rnd_d();
            mode      = 1'($urandom_range(0, 1));
            signed_in = 1'($urandom_range(0, 1));
            tick();
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (LAT + 5) tick();
        chk("drain_outstanding", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
